dmem_port_arbiter: RTL

- Shares the single-port 64-bit data memory (10-bit doubleword address, 8-bit byte write strobe, 1-cycle read latency) between two requesters.
- Requesters: the pipeline MEM stage (cpu) and a DMA/debug/video-fill master (dma).
- The CPU has priority. A starvation counter and a bounded DMA burst lock guarantee forward progress for both sides.
- Sits between the MEM stage and the dmem macro. The video-register shadow stays in the MEM stage.

---
 rtl/dmem_port_arbiter_pkg.sv | 18 +
 rtl/dmem_rd_return.sv | 30 +++
 rtl/dmem_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: dmem geometry,
// arbitration limits, owner encoding and grant-FSM states.
package dmem_port_arbiter_pkg;

    localparam int DMEM_ADDR_W    = 10;
    localparam int DMEM_DATA_W    = 64;
    localparam int DEF_STARVE_MAX = 4;
    localparam int DEF_BURST_MAX  = 8;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef enum logic {
        S_CPU   = 1'b0,
        S_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_rd_return.sv
// Tracks the single outstanding dmem read and steers its one-cycle rvalid
// back to whichever requester issued it.
module dmem_rd_return
    import dmem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rd_xfer,
    input  logic rd_granter,
    output logic cpu_rvalid,
    output logic dma_rvalid
);

    logic rd_pend;
    logic rd_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_CPU;
        end else begin
            rd_pend  <= rd_xfer;
            rd_owner <= rd_granter;
        end
    end

    assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
    assign dma_rvalid = rd_pend && (rd_owner == OWN_DMA);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM stage and the DMA master:
// CPU priority, starvation relief for the DMA, and bounded locked DMA bursts.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,

    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic                cpu_we,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,

    input  logic                dma_req_valid,
    output logic                dma_req_ready,
    input  logic                dma_we,
    input  logic [DATA_W/8-1:0] dma_wstrb,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic [DATA_W-1:0]   dma_wdata,
    output logic                dma_rvalid,
    output logic [DATA_W-1:0]   dma_rdata,
    input  logic                dma_lock,

    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_wea,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                grant_dma
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int BURST_W  = $clog2(BURST_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [BURST_W-1:0]  BURST_LIM  = BURST_W'(BURST_MAX);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [STARVE_W-1:0]  starve_cnt;
    logic [BURST_W-1:0]   beat_cnt;
    logic [BURST_W-1:0]   beat_inc;
    logic                 sel_cpu;
    logic                 sel_dma;
    logic                 rd_xfer;

    assign beat_inc = beat_cnt + 1'b1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_CPU;
        end else begin
            state <= state_next;
        end
    end

    // A burst ends on an unlocked beat, on lock release while idle, or once
    // BURST_MAX beats have gone through so the CPU gets at least one slot.
    always_comb begin
        state_next = state;
        case (state)
            S_CPU: begin
                if (sel_dma && dma_lock) begin
                    state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (dma_req_valid) begin
                    if (!dma_lock || (beat_inc == BURST_LIM)) begin
                        state_next = S_CPU;
                    end
                end else if (!dma_lock) begin
                    state_next = S_CPU;
                end
            end
            default: state_next = S_CPU;
        endcase
    end

    always_comb begin
        sel_cpu = 1'b0;
        sel_dma = 1'b0;
        case (state)
            S_CPU: begin
                sel_cpu = cpu_req_valid && (starve_cnt < STARVE_LIM);
                sel_dma = !sel_cpu && dma_req_valid;
            end
            S_BURST: begin
                sel_dma = dma_req_valid;
            end
            default: begin
                sel_cpu = 1'b0;
                sel_dma = 1'b0;
            end
        endcase

        cpu_req_ready = sel_cpu;
        dma_req_ready = sel_dma;
        grant_dma     = (state == S_BURST) || sel_dma;
        mem_en        = sel_cpu || sel_dma;
        mem_addr      = sel_dma ? dma_addr  : cpu_addr;
        mem_wdata     = sel_dma ? dma_wdata : cpu_wdata;
        if (sel_dma) begin
            mem_wea = dma_we ? dma_wstrb : '0;
        end else if (sel_cpu) begin
            mem_wea = cpu_we ? cpu_wstrb : '0;
        end else begin
            mem_wea = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            starve_cnt <= '0;
            beat_cnt   <= '0;
        end else begin
            if (!dma_req_valid || sel_dma) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (state_next == S_BURST) begin
                if (state == S_CPU) begin
                    beat_cnt <= BURST_W'(1);
                end else if (sel_dma) begin
                    beat_cnt <= beat_inc;
                end
            end else begin
                beat_cnt <= '0;
            end
        end
    end

    assign rd_xfer   = (sel_cpu && !cpu_we) || (sel_dma && !dma_we);
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    dmem_rd_return u_rd_return (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .rd_xfer    (rd_xfer),
        .rd_granter (sel_dma ? OWN_DMA : OWN_CPU),
        .cpu_rvalid (cpu_rvalid),
        .dma_rvalid (dma_rvalid)
    );

endmodule
